host_load_ctrl: RTL and testbench
=================================

Name: host_load_ctrl

Overview:
- Byte-stream host command controller sitting directly upstream of the CPU core's external debug/load port.
- Assembles opcode/address/data packets from a UART-side byte stream, and drives the core's cmd/addr_in/data_in.
- Captures the core's data_out for reads and serializes responses back to the host.
- Owns the core's reset, so programs are loaded while the CPU is held and released on command.

Parameters:
- READ_LAT, 2, cycles between driving a read command and sampling host_rdata (covers BRAM output latency).
- ACK_BYTE, 8'hA5, response byte for completed write/run/halt.
- ERR_BYTE, 8'hEE, response byte for an unknown opcode.
- TIMEOUT_CYCLES, 65535, inter-byte idle limit; used only with HOST_TIMEOUT_EN.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  controller accepts byte this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte.
- host_cmd  out  2  to core cmd: 00 reg read, 01 I-mem write, 10 D-mem read, 11 D-mem write.
- host_addr  out  32  to core addr_in.
- host_wdata  out  32  to core data_in.
- host_rdata  in  32  from core data_out.
- cpu_reset  out  1  active-high reset to the core.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rx_ready=1, tx_valid=0, tx_data=0.
  - host_cmd=00, host_addr=0, host_wdata=0, cpu_reset=1 (core held after power-up), busy=0.
- Byte transfer rules:
  - An rx byte is accepted when rx_valid && rx_ready.
  - A tx byte completes when tx_valid && tx_ready.
  - tx_valid and tx_data stay stable until the byte is accepted.
- Packet format (multi-byte fields little-endian):
  - Opcode byte first.
  - 0x00 reg read: 4 addr bytes.
  - 0x01 I-mem write: 4 addr + 4 data bytes.
  - 0x02 D-mem read: 4 addr bytes.
  - 0x03 D-mem write: 4 addr + 4 data bytes.
  - 0x10 run: no payload; cpu_reset<=0.
  - 0x11 halt: no payload; cpu_reset<=1.
- States:
  - IDLE: rx_ready=1. On accepted opcode:
    - read/write opcodes -> ADDR, byte counter=0.
    - 0x10/0x11 -> update cpu_reset, load ACK_BYTE -> RESP.
    - other -> load ERR_BYTE -> RESP (no payload consumed).
  - ADDR: rx_ready=1. Shift 4 bytes into host_addr (byte n to bits [8n+7:8n]).
    - After the 4th: reads -> EXEC; writes -> DATA.
  - DATA: rx_ready=1. Shift 4 bytes into host_wdata, then -> EXEC.
  - EXEC:
    - Writes: host_cmd=01/11 for exactly one cycle, then load ACK_BYTE -> RESP.
    - Reads: host_cmd=00/10 -> WAIT.
  - WAIT: host_cmd held, counter runs READ_LAT cycles.
    - On the last cycle, latch host_rdata into a 32-bit response register, then -> RESP with 4 bytes pending.
  - RESP: rx_ready=0, tx_valid=1.
    - Read responses send 4 bytes, LSB first; others send one byte.
    - After the final accepted byte -> IDLE, host_cmd=00.
- host_cmd is 00 in every state other than EXEC/WAIT.
  - 00 never writes core memory, so idle is side-effect free.
  - The write codes 01/11 never persist more than one cycle.
- host_addr and host_wdata hold their values after a command until overwritten.
- Writes and reads are allowed while cpu_reset=0; ordering versus core traffic is the host's responsibility.
- Run while already running, or halt while already halted: still ACK, no other effect.
- Reset mid-packet: partial packet discarded and all outputs return to reset values; cpu_reset returns to 1.
- rx_valid while rx_ready=0: byte not consumed; it is the upstream's duty to hold it.

Optional Feature:
- Macro: HOST_TIMEOUT_EN.
- Defined:
  - In ADDR/DATA, a counter resets on each accepted byte.
  - Reaching TIMEOUT_CYCLES with no byte abandons the packet: no core command is issued, ERR_BYTE is sent, then IDLE.
  - Counter is not active in IDLE, EXEC, WAIT or RESP.
- Undefined: no counter; the controller waits indefinitely for packet bytes.

Test Plan:
- Reset, then bytes 01 00 00 00 00 13 05 A0 00 -> host_cmd=01 for exactly 1 cycle with host_addr=0x00000000, host_wdata=0x00A00513; tx 0xA5; cpu_reset still 1.
- Bytes 02 08 00 00 00 with host_rdata forced to 0xDEADBEEF by the end of WAIT -> host_cmd=10 for READ_LAT+1 cycles; tx EF BE AD DE in order.
- Bytes 10 -> cpu_reset falls to 0 after the opcode is accepted, tx 0xA5; then 11 -> cpu_reset=1, tx 0xA5.
- Opcode 0x7F -> tx 0xEE, no host_cmd change; next packet 00 05 00 00 00 decodes normally (reg read, addr 5).
- tx_ready held low 10 cycles during a read response -> tx_data stable, rx_ready=0 throughout; with HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, sending 03 00 then silence -> 0xEE after 16 cycles, and no host_cmd=11 pulse ever occurs.
- Assert reset during DATA of a write -> no write pulse, cpu_reset=1, next full packet accepted correctly.

Source files
------------

// File: rtl/host_load_ctrl.sv
// Host byte-stream command controller in front of the core's debug/load port.
// Optional inter-byte timeout in ADDR/DATA is enabled by defining HOST_TIMEOUT_EN.
module host_load_ctrl #(
  parameter int unsigned READ_LAT       = 2,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  host_cmd,
  output logic [31:0] host_addr,
  output logic [31:0] host_wdata,
  input  logic [31:0] host_rdata,
  output logic        cpu_reset,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_e;

  // READ_LAT must be at least 1; WAIT always spends READ_LAT cycles.
  localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    resp_left_q, resp_left_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          rx_fire, tx_fire;
  logic          in_payload;
  logic          timeout;

  assign in_payload = (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_ready   = (state_q == S_IDLE) || in_payload;
  assign tx_valid   = (state_q == S_RESP);
  assign tx_data    = resp_q[7:0];
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  // The opcode's low two bits are exactly the core command encoding.
  assign host_cmd   = ((state_q == S_EXEC) || (state_q == S_WAIT)) ? op_q : 2'b00;
  assign host_addr  = addr_q;
  assign host_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = (state_q != S_IDLE);

`ifdef HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (in_payload && !rx_fire) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout = in_payload && !rx_fire && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    byte_cnt_d  = byte_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    cpu_reset_d = cpu_reset_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data[7:2] == 6'd0) begin
            op_d       = rx_data[1:0];
            byte_cnt_d = 2'd0;
            state_d    = S_ADDR;
          end else if (rx_data[7:1] == 7'b0001000) begin
            // 0x10 releases the core, 0x11 holds it; repeats are harmless.
            cpu_reset_d = rx_data[0];
            resp_d      = {24'd0, ACK_BYTE};
            resp_left_d = 3'd1;
            state_d     = S_RESP;
          end else begin
            resp_d      = {24'd0, ERR_BYTE};
            resp_left_d = 3'd1;
            state_d     = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (timeout) begin
          resp_d      = {24'd0, ERR_BYTE};
          resp_left_d = 3'd1;
          state_d     = S_RESP;
        end else if (rx_fire) begin
          // Right shift: after four bytes, byte n sits at bits [8n+7:8n].
          addr_d     = {rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = op_q[0] ? S_DATA : S_EXEC;
          end
        end
      end

      S_DATA: begin
        if (timeout) begin
          resp_d      = {24'd0, ERR_BYTE};
          resp_left_d = 3'd1;
          state_d     = S_RESP;
        end else if (rx_fire) begin
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (op_q[0]) begin
          resp_d      = {24'd0, ACK_BYTE};
          resp_left_d = 3'd1;
          state_d     = S_RESP;
        end else begin
          lat_cnt_d = '0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (lat_cnt_q == LW'(READ_LAT - 1)) begin
          resp_d      = host_rdata;
          resp_left_d = 3'd4;
          state_d     = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          if (resp_left_q == 3'd1) begin
            state_d = S_IDLE;
          end else begin
            resp_d      = {8'd0, resp_q[31:8]};
            resp_left_d = resp_left_q - 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      byte_cnt_q  <= 2'd0;
      lat_cnt_q   <= '0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      resp_q      <= 32'd0;
      resp_left_q <= 3'd0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      byte_cnt_q  <= byte_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

endmodule

// File: tb/tb_host_load_ctrl.sv
// Directed plus randomized packet-level checks of host_load_ctrl against a
// transaction model (expected responses, command pulses, held address/data/cpu_reset).
module tb_host_load_ctrl;

  localparam int         READ_LAT = 2;
  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] ERR      = 8'hEE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [1:0]  host_cmd;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata = 32'd0;
  logic        cpu_reset;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  host_load_ctrl #(
    .READ_LAT(READ_LAT),
    .ACK_BYTE(ACK),
    .ERR_BYTE(ERR),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .host_cmd(host_cmd),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .cpu_reset(cpu_reset),
    .busy(busy)
  );

  // Core-side observer: totals of write pulses and D-mem read cycles.
  int          wr_pulses = 0;
  int          rd_cycles = 0;
  int          wr_run = 0;
  int          max_wr_run = 0;
  logic [1:0]  last_wr_cmd = 2'b00;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  always @(negedge clk) begin
    if (host_cmd[0]) begin
      wr_pulses    <= wr_pulses + 1;
      wr_run       <= wr_run + 1;
      max_wr_run   <= (wr_run + 1 > max_wr_run) ? wr_run + 1 : max_wr_run;
      last_wr_cmd  <= host_cmd;
      last_wr_addr <= host_addr;
      last_wr_data <= host_wdata;
    end else begin
      wr_run <= 0;
    end
    if (host_cmd == 2'b10) begin
      rd_cycles <= rd_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc;
    cyc = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    send_byte(op);
    if (op <= 8'h03) begin
      for (int k = 0; k < 4; k++) send_byte(8'(addr >> (8 * k)));
      if (op[0]) begin
        for (int k = 0; k < 4; k++) send_byte(8'(data >> (8 * k)));
      end
    end
  endtask

  // Collects nbytes response bytes with random tx_ready back-pressure.
  task automatic recv_expect(input string tag, input logic [31:0] val, input int nbytes);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < nbytes && cyc < 500) begin
      @(negedge clk);
      cyc++;
      tx_ready = ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_ready) begin
        check($sformatf("%s_byte%0d", tag, got), 32'(tx_data), 32'(8'(val >> (8 * got))));
        got++;
      end
    end
    check({tag, "_count"}, 32'(got), 32'(nbytes));
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, tx_valid}, 32'd0);
  endtask

  initial begin
    int          wp0;
    int          rc0;
    int          n;
    int          sel;
    logic [7:0]  op;
    logic [7:0]  held;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] r;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_cpu;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_host_cmd", 32'(host_cmd), 32'd0);
    check("rst_host_addr", host_addr, 32'd0);
    check("rst_host_wdata", host_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // I-mem write while the core is held
    wp0 = wr_pulses;
    send_pkt(8'h01, 32'h0000_0000, 32'h00A0_0513);
    recv_expect("imem_wr_ack", {24'd0, ACK}, 1);
    check("imem_wr_pulses", 32'(wr_pulses - wp0), 32'd1);
    check("imem_wr_len", 32'(max_wr_run), 32'd1);
    check("imem_wr_cmd", 32'(last_wr_cmd), 32'd1);
    check("imem_wr_addr", last_wr_addr, 32'h0000_0000);
    check("imem_wr_data", last_wr_data, 32'h00A0_0513);
    check("imem_wr_cpu_reset", 32'(cpu_reset), 32'd1);

    // D-mem read: command held READ_LAT+1 cycles, response LSB first
    host_rdata = 32'hDEAD_BEEF;
    rc0 = rd_cycles;
    send_pkt(8'h02, 32'h0000_0008, 32'd0);
    recv_expect("dmem_rd", 32'hDEAD_BEEF, 4);
    check("dmem_rd_cycles", 32'(rd_cycles - rc0), 32'(READ_LAT + 1));
    check("dmem_rd_addr", host_addr, 32'h0000_0008);

    // Run then halt
    send_byte(8'h10);
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    recv_expect("run_ack", {24'd0, ACK}, 1);
    send_byte(8'h11);
    check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    recv_expect("halt_ack", {24'd0, ACK}, 1);

    // Unknown opcode, then a normal register read
    wp0 = wr_pulses;
    rc0 = rd_cycles;
    send_byte(8'h7F);
    recv_expect("unk_err", {24'd0, ERR}, 1);
    check("unk_no_cmd", 32'((wr_pulses - wp0) + (rd_cycles - rc0)), 32'd0);
    check("unk_addr_held", host_addr, 32'h0000_0008);
    host_rdata = 32'h1234_5678;
    send_pkt(8'h00, 32'h0000_0005, 32'd0);
    recv_expect("reg_rd", 32'h1234_5678, 4);
    check("reg_rd_addr", host_addr, 32'h0000_0005);

    // Back-pressure on a read response; a stray rx byte must not be consumed
    host_rdata = 32'hCAFE_F00D;
    send_pkt(8'h02, 32'h0000_0100, 32'd0);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    held     = tx_data;
    rx_data  = 8'h7F;
    rx_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_tx_data", 32'(tx_data), 32'(held));
      check("stall_rx_ready", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    recv_expect("stall_rd", 32'hCAFE_F00D, 4);

`ifdef HOST_TIMEOUT_EN
    // Abandoned D-mem write: ERR after 16 idle cycles and no write pulse
    wp0 = wr_pulses;
    send_byte(8'h03);
    send_byte(8'h00);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(n), 32'd16);
    recv_expect("tmo_err", {24'd0, ERR}, 1);
    check("tmo_no_write", 32'(wr_pulses - wp0), 32'd0);
`endif

    // Reset asserted in the middle of DATA
    send_byte(8'h10);
    recv_expect("run2_ack", {24'd0, ACK}, 1);
    wp0 = wr_pulses;
    send_byte(8'h03);
    for (int k = 0; k < 4; k++) send_byte(8'h40 + 8'(k));
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_no_write", 32'(wr_pulses - wp0), 32'd0);
    check("mid_rst_addr", host_addr, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    send_pkt(8'h03, 32'h0000_0040, 32'h1122_3344);
    recv_expect("post_rst_ack", {24'd0, ACK}, 1);
    check("post_rst_pulses", 32'(wr_pulses - wp0), 32'd1);
    check("post_rst_cmd", 32'(last_wr_cmd), 32'd3);
    check("post_rst_addr", last_wr_addr, 32'h0000_0040);
    check("post_rst_data", last_wr_data, 32'h1122_3344);

    // Randomized packets against the transaction model
    exp_addr  = 32'h0000_0040;
    exp_wdata = 32'h1122_3344;
    exp_cpu   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1, 2, 3: op = 8'(sel);
        4:          op = 8'h10;
        5:          op = 8'h11;
        default: begin
          op = 8'($urandom_range(4, 255));
          if (op == 8'h10 || op == 8'h11) op = 8'h7F;
        end
      endcase
      a = $urandom;
      d = $urandom;
      r = $urandom;
      host_rdata = r;
      wp0 = wr_pulses;
      rc0 = rd_cycles;
      send_pkt(op, a, d);
      if (op <= 8'h03) begin
        exp_addr = a;
        if (op[0]) exp_wdata = d;
      end
      if (op == 8'h10) exp_cpu = 1'b0;
      if (op == 8'h11) exp_cpu = 1'b1;
      if (op == 8'h00 || op == 8'h02) begin
        recv_expect($sformatf("rnd%0d_rd", i), r, 4);
      end else if (op <= 8'h03 || op == 8'h10 || op == 8'h11) begin
        recv_expect($sformatf("rnd%0d_ack", i), {24'd0, ACK}, 1);
      end else begin
        recv_expect($sformatf("rnd%0d_err", i), {24'd0, ERR}, 1);
      end
      check($sformatf("rnd%0d_wr_pulses", i), 32'(wr_pulses - wp0),
            (op == 8'h01 || op == 8'h03) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_rd_cycles", i), 32'(rd_cycles - rc0),
            (op == 8'h02) ? 32'(READ_LAT + 1) : 32'd0);
      if (op == 8'h01 || op == 8'h03) begin
        check($sformatf("rnd%0d_wr_cmd", i), 32'(last_wr_cmd), 32'(op[1:0]));
        check($sformatf("rnd%0d_wr_addr", i), last_wr_addr, a);
        check($sformatf("rnd%0d_wr_data", i), last_wr_data, d);
      end
      check($sformatf("rnd%0d_addr", i), host_addr, exp_addr);
      check($sformatf("rnd%0d_wdata", i), host_wdata, exp_wdata);
      check($sformatf("rnd%0d_cpu_reset", i), 32'(cpu_reset), 32'(exp_cpu));
      check($sformatf("rnd%0d_host_cmd", i), 32'(host_cmd), 32'd0);
    end
    check("wr_pulse_max_len", 32'(max_wr_run), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
